// File: rtl/mux_2_1_rr_arbiter.sv
// Round-robin owner of a shared 2:1 mux with a registered output stage.
// Optional per-grant hold limit is compiled in with `define MUX_ARB_HOLD_LIMIT_EN.
module mux_2_1_rr_arbiter #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              req_0,
  input  logic              req_1,
  input  logic [DATA_W-1:0] in_0,
  input  logic [DATA_W-1:0] in_1,
  input  logic              vld_0,
  input  logic              vld_1,
  output logic              gnt_0,
  output logic              gnt_1,
  output logic              sel_0,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid
);

  typedef enum logic [1:0] {StIdle, StG0, StG1} state_e;

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic              sel_q, sel_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              hold_expired;

  if (MAX_HOLD < 2) begin : gen_max_hold_check
    $error("MAX_HOLD must be at least 2");
  end

`ifdef MUX_ARB_HOLD_LIMIT_EN
  localparam int unsigned     CntW   = $clog2(MAX_HOLD);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_HOLD - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign hold_expired = (cnt_q == CntMax);

  // Cleared on every new grant, saturating while the same grant is held.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d == StIdle || state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign hold_expired = 1'b0;
`endif

  // State and registered outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      sel_q   <= 1'b1;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  // Next-state: a released grant hands over directly when the other side is waiting.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_0 && req_1) begin
          state_d = last_q ? StG0 : StG1;
        end else if (req_0) begin
          state_d = StG0;
        end else if (req_1) begin
          state_d = StG1;
        end
      end
      StG0: begin
        if (!req_0 || (hold_expired && req_1)) begin
          state_d = req_1 ? StG1 : StIdle;
        end
      end
      StG1: begin
        if (!req_1 || (hold_expired && req_0)) begin
          state_d = req_0 ? StG0 : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: pointer and select follow the next owner, the data stage follows the current one.
  always_comb begin
    last_d  = last_q;
    sel_d   = sel_q;
    data_d  = data_q;
    valid_d = 1'b0;
    if (state_d == StG0) begin
      last_d = 1'b0;
      sel_d  = 1'b1;
    end else if (state_d == StG1) begin
      last_d = 1'b1;
      sel_d  = 1'b0;
    end
    unique case (state_q)
      StG0: begin
        data_d  = in_0;
        valid_d = vld_0;
      end
      StG1: begin
        data_d  = in_1;
        valid_d = vld_1;
      end
      default: ;
    endcase
  end

  assign gnt_0     = (state_q == StG0);
  assign gnt_1     = (state_q == StG1);
  assign sel_0     = sel_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_2_1_rr_arbiter.sv
// Bench for mux_2_1_rr_arbiter: directed scenarios plus randomized traffic
// checked against an ownership/tenure model of the arbitration rules.
module tb_mux_2_1_rr_arbiter;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned MAX_HOLD = 4;
`ifdef MUX_ARB_HOLD_LIMIT_EN
  localparam bit HOLD_ON = 1'b1;
`else
  localparam bit HOLD_ON = 1'b0;
`endif
  localparam int IDLE = 2;

  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b1;
  logic              req_0 = 1'b0, req_1 = 1'b0;
  logic [DATA_W-1:0] in_0 = '0, in_1 = '0;
  logic              vld_0 = 1'b0, vld_1 = 1'b0;
  logic              gnt_0, gnt_1, sel_0, out_valid;
  logic [DATA_W-1:0] out_data;

  int n_cmp = 0;
  int n_bad = 0;

  mux_2_1_rr_arbiter #(
    .DATA_W   (DATA_W),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .req_0     (req_0),
    .req_1     (req_1),
    .in_0      (in_0),
    .in_1      (in_1),
    .vld_0     (vld_0),
    .vld_1     (vld_1),
    .gnt_0     (gnt_0),
    .gnt_1     (gnt_1),
    .sel_0     (sel_0),
    .out_data  (out_data),
    .out_valid (out_valid)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model: owner (0, 1 or IDLE), the most recent winner, and how many
  // cycles the current owner has held the mux.
  int              m_owner  = IDLE;
  bit              m_last   = 1'b1;
  bit              m_sel    = 1'b1;
  logic [DATA_W-1:0] m_data = '0;
  bit              m_valid  = 1'b0;
  int              m_tenure = 0;
  int              m_nxt;

  function automatic int next_owner(int owner, bit lst, int tenure, bit r0, bit r1);
    bit r[2];
    r[0] = r0;
    r[1] = r1;
    if (owner == IDLE) begin
      if (r0 && r1) return lst ? 0 : 1;
      if (r0) return 0;
      if (r1) return 1;
      return IDLE;
    end
    if (!r[owner]) return r[1-owner] ? 1 - owner : IDLE;
    if (HOLD_ON && tenure >= MAX_HOLD && r[1-owner]) return 1 - owner;
    return owner;
  endfunction

  always_comb m_nxt = next_owner(m_owner, m_last, m_tenure, req_0, req_1);

  always @(posedge sys_clk) begin
    if (sys_rst) begin
      m_owner  <= IDLE;
      m_last   <= 1'b1;
      m_sel    <= 1'b1;
      m_data   <= '0;
      m_valid  <= 1'b0;
      m_tenure <= 0;
    end else begin
      m_valid <= (m_owner == 0) ? vld_0 : (m_owner == 1) ? vld_1 : 1'b0;
      if (m_owner == 0) m_data <= in_0;
      else if (m_owner == 1) m_data <= in_1;
      m_owner  <= m_nxt;
      m_tenure <= (m_nxt == IDLE) ? 0 : (m_nxt == m_owner) ? m_tenure + 1 : 1;
      if (m_nxt != IDLE) begin
        m_last <= (m_nxt == 1);
        m_sel  <= (m_nxt == 0);
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    req_0 = 1'b0; req_1 = 1'b0; vld_0 = 1'b0; vld_1 = 1'b0;
    tick();
    tick();
    sys_rst = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    req_0 = 1'b1; req_1 = 1'b1;
    repeat (3) tick();
    n_cmp++; if (gnt_0 !== 1'b0) begin n_bad++; $display("FAIL reset_gnt_0: got %b want 0", gnt_0); end
    n_cmp++; if (gnt_1 !== 1'b0) begin n_bad++; $display("FAIL reset_gnt_1: got %b want 0", gnt_1); end
    n_cmp++; if (sel_0 !== 1'b1) begin n_bad++; $display("FAIL reset_sel_0: got %b want 1", sel_0); end
    n_cmp++; if (out_data !== 8'h00) begin n_bad++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    sys_rst = 1'b0;
    tick();
    n_cmp++; if (gnt_0 !== 1'b1) begin n_bad++; $display("FAIL release_gnt_0: got %b want 1", gnt_0); end
    n_cmp++; if (gnt_1 !== 1'b0) begin n_bad++; $display("FAIL release_gnt_1: got %b want 0", gnt_1); end
    n_cmp++; if (sel_0 !== 1'b1) begin n_bad++; $display("FAIL release_sel_0: got %b want 1", sel_0); end
  endtask

  task automatic test_tie_rotation();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      int w = i % 2;
      req_0 = 1'b1; req_1 = 1'b1;
      tick();
      n_cmp++; if (gnt_0 !== (w == 0)) begin n_bad++; $display("FAIL tie_gnt_0[%0d]: got %b want %b", i, gnt_0, w == 0); end
      n_cmp++; if (gnt_1 !== (w == 1)) begin n_bad++; $display("FAIL tie_gnt_1[%0d]: got %b want %b", i, gnt_1, w == 1); end
      req_0 = 1'b0; req_1 = 1'b0;
      if (w == 0) begin vld_0 = 1'b1; in_0 = 8'(8'h40 + i); end
      else begin vld_1 = 1'b1; in_1 = 8'(8'h40 + i); end
      tick();
      vld_0 = 1'b0; vld_1 = 1'b0;
      n_cmp++; if ({gnt_0, gnt_1} !== 2'b00) begin n_bad++; $display("FAIL tie_idle[%0d]: got %b%b want 00", i, gnt_0, gnt_1); end
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'(8'h40 + i)) begin
        n_bad++; $display("FAIL tie_data[%0d]: got %b/%h want 1/%h", i, out_valid, out_data, 8'(8'h40 + i));
      end
    end
  endtask

  task automatic test_handover();
    do_reset();
    req_0 = 1'b1;
    tick();
    n_cmp++; if (gnt_0 !== 1'b1 || sel_0 !== 1'b1) begin n_bad++; $display("FAIL ho_g0: got gnt_0=%b sel_0=%b want 1/1", gnt_0, sel_0); end
    in_0 = 8'hA5; vld_0 = 1'b1; req_0 = 1'b0; req_1 = 1'b1;
    tick();
    vld_0 = 1'b0;
    n_cmp++; if (out_data !== 8'hA5 || out_valid !== 1'b1) begin n_bad++; $display("FAIL ho_data0: got %b/%h want 1/a5", out_valid, out_data); end
    n_cmp++; if (gnt_1 !== 1'b1 || gnt_0 !== 1'b0) begin n_bad++; $display("FAIL ho_gnt_1: got %b%b want 01", gnt_0, gnt_1); end
    n_cmp++; if (sel_0 !== 1'b0) begin n_bad++; $display("FAIL ho_sel_0: got %b want 0", sel_0); end
    in_1 = 8'h3C; vld_1 = 1'b1;
    tick();
    vld_1 = 1'b0;
    n_cmp++; if (out_data !== 8'h3C || out_valid !== 1'b1) begin n_bad++; $display("FAIL ho_data1: got %b/%h want 1/3c", out_valid, out_data); end
    req_1 = 1'b0;
    tick();
  endtask

  task automatic test_ungranted_valid();
    do_reset();
    req_0 = 1'b1;
    tick();
    in_0 = 8'h11; vld_0 = 1'b1;
    tick();
    n_cmp++; if (out_data !== 8'h11 || out_valid !== 1'b1) begin n_bad++; $display("FAIL ug_setup: got %b/%h want 1/11", out_valid, out_data); end
    vld_0 = 1'b0; vld_1 = 1'b1; in_1 = 8'hFF;
    tick();
    vld_1 = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ug_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 8'h11) begin n_bad++; $display("FAIL ug_data: got %h want 11", out_data); end
    req_0 = 1'b0;
    tick();
  endtask

  task automatic test_hold_limit();
    do_reset();
    req_0 = 1'b1; req_1 = 1'b1;
    for (int k = 0; k < 16; k++) begin
      bit exp0;
      tick();
      exp0 = HOLD_ON ? ((k / MAX_HOLD) % 2 == 0) : 1'b1;
      n_cmp++; if (gnt_0 !== exp0 || gnt_1 !== !exp0) begin
        n_bad++; $display("FAIL hold[%0d]: got %b%b want %b%b", k, gnt_0, gnt_1, exp0, !exp0);
      end
    end
    req_0 = 1'b0; req_1 = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req_1 = 1'b1;
    tick();
    in_1 = 8'h5A; vld_1 = 1'b1;
    tick();
    n_cmp++; if (gnt_1 !== 1'b1 || out_valid !== 1'b1) begin n_bad++; $display("FAIL rmg_setup: got gnt_1=%b vld=%b want 1/1", gnt_1, out_valid); end
    sys_rst = 1'b1;
    tick();
    vld_1 = 1'b0;
    n_cmp++; if (gnt_1 !== 1'b0) begin n_bad++; $display("FAIL rmg_gnt_1: got %b want 0", gnt_1); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rmg_valid: got %b want 0", out_valid); end
    n_cmp++; if (sel_0 !== 1'b1) begin n_bad++; $display("FAIL rmg_sel_0: got %b want 1", sel_0); end
    sys_rst = 1'b0; req_0 = 1'b1; req_1 = 1'b1;
    tick();
    n_cmp++; if (gnt_0 !== 1'b1) begin n_bad++; $display("FAIL rmg_last: got gnt_0=%b want 1", gnt_0); end
    req_0 = 1'b0; req_1 = 1'b0;
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(3) == 0) req_0 = ~req_0;
      if ($urandom_range(3) == 0) req_1 = ~req_1;
      vld_0 = 1'($urandom);
      vld_1 = 1'($urandom);
      in_0 = 8'($urandom);
      in_1 = 8'($urandom);
      sys_rst = ($urandom_range(59) == 0);
      tick();
      n_cmp++; if (gnt_0 !== (m_owner == 0) || gnt_1 !== (m_owner == 1)) begin
        n_bad++; $display("FAIL rnd_gnt[%0d]: got %b%b want owner %0d", c, gnt_0, gnt_1, m_owner);
      end
      n_cmp++; if (sel_0 !== m_sel) begin n_bad++; $display("FAIL rnd_sel[%0d]: got %b want %b", c, sel_0, m_sel); end
      n_cmp++; if (out_valid !== m_valid) begin n_bad++; $display("FAIL rnd_valid[%0d]: got %b want %b", c, out_valid, m_valid); end
      n_cmp++; if (out_data !== m_data) begin n_bad++; $display("FAIL rnd_data[%0d]: got %h want %h", c, out_data, m_data); end
    end
    sys_rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_tie_rotation();
    test_handover();
    test_ungranted_valid();
    test_hold_limit();
    test_reset_mid_grant();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
